xif_coproc_tracker: RTL and testbench
=====================================

# xif_coproc_tracker

Parametrised CORE-V X-interface front end for single-operand immediate accelerators, replacing the one-instruction-in-flight wrapper style. Accepts matching instructions into a DEPTH-entry in-order ring buffer, holds each until its commit arrives, then dispatches it to the accelerator. Killed instructions are dropped without dispatch. Results return to the core in issue order with their XIF id and rd. Sits between the core's issue/commit/result channels and an accelerator with a valid/ready datapath.

## Interface
- WIDTH, 32, operand/result width
- IMM_WIDTH, 12, immediate width taken from instr[31:32-IMM_WIDTH]
- ID_WIDTH, 4, XIF instruction id width
- DEPTH, 4, buffer entries (power of two, ≥2)
- OPCODE, 7'b1110111, matched against instr[6:0]
- FUNC3, 3'b000, matched against instr[14:12]
- clk_i in 1: clock
- rst_i in 1: reset; one clock, synchronous, active-high
- issue_valid_i in 1: XIF issue valid
- issue_ready_o out 1: XIF issue ready
- issue_instr_i in 32: instruction word
- issue_id_i in ID_WIDTH: instruction id
- issue_rs1_i in WIDTH: rs1 value
- issue_rs1_valid_i in 1: rs1 value valid
- issue_accept_o out 1: instruction accepted
- issue_writeback_o out 1: rd writeback will occur
- commit_valid_i in 1: commit valid
- commit_id_i in ID_WIDTH: committed id
- commit_kill_i in 1: kill flag
- acc_valid_o out 1: dispatch valid
- acc_ready_i in 1: accelerator ready
- acc_rs1_o out WIDTH: operand
- acc_imm_o out IMM_WIDTH: immediate
- acc_valid_i in 1: accelerator result valid; results return in dispatch order
- acc_ready_o out 1: result ready
- acc_result_i in WIDTH: result
- result_valid_o out 1: XIF result valid
- result_ready_i in 1: XIF result ready
- result_id_o out ID_WIDTH: result id
- result_rd_o out 5: destination register
- result_we_o out 1: write enable
- result_data_o out WIDTH: result data

## Operation
- Entry states: FREE, ISSUED, COMMITTED, DISPATCHED, DONE, KILLED. Each entry stores id, rd (instr[11:7]), rs1, imm and result.
- Match rule: opcode and func3 both equal the parameters.
- issue_accept_o and issue_writeback_o equal the match rule (combinational).
- issue_ready_o = !full && (!match || issue_rs1_valid_i).
- Issue handshake with a match: writes the tail entry as ISSUED and advances the tail.
- Issue handshake without a match: accept=0; no entry is written.
- Commit: a CAM lookup on id over non-FREE entries. An ISSUED entry becomes COMMITTED on commit, or KILLED if commit_kill_i is set.
  - An unmatched id is ignored.
  - A commit carrying the id being issued in the same cycle applies to the new entry via bypass.
- Dispatch pointer: walks entries in order.
  - COMMITTED entry: drive acc_valid_o. On handshake, the entry becomes DISPATCHED and the pointer advances.
  - KILLED entry: skipped, one per cycle.
  - ISSUED entry: the pointer stalls.
- acc_ready_o is always 1. A result handshake fills the oldest DISPATCHED entry, which becomes DONE.
- Head pointer:
  - DONE entry: drive the result outputs with result_we_o=1. On handshake, free the entry and advance the pointer.
  - KILLED entry at head and already passed by the dispatch pointer: freed silently, one per cycle.
- Duplicate ids in flight are illegal per XIF and are not checked.

## Timing
- Reset: all entries FREE, pointers and count 0. issue_ready_o=1. acc_valid_o=result_valid_o=result_we_o=0. All data outputs 0.
- Issue and commit in cycle 0 → acc_valid_o in cycle 1.
- Accelerator result in cycle k → result_valid_o in cycle k+1.
- Minimum issue-to-result latency is 2 cycles plus accelerator latency.
- full and count are registered. A free in the same cycle does not raise issue_ready_o until the next cycle.
- Simultaneous issue and free update count by +1−1 = unchanged.
- Pointers wrap modulo DEPTH. full when count==DEPTH; empty when count==0.
- result_* and acc_* outputs are stable while valid and not ready.
- Reset asserted mid-operation discards all entries. No result is emitted for them.

## Configuration
- XIF_COPROC_TRACKER_STATS_EN:
  - Defined: 32-bit saturating counters issued_cnt_o, killed_cnt_o and retired_cnt_o are added as outputs. They are reset by rst_i.
  - Undefined: these ports and their logic are absent. Functional behaviour is identical.

## Structure
- Package xif_coproc_tracker_pkg holds:
  - entry_state_e enum
  - entry_t struct (state, id, rd, rs1, imm, result)
  - default OPCODE/FUNC3 constants
- Sub-module xif_coproc_tracker_stats holds the three counters and is instantiated only under the macro.

## Test plan
- Single instruction: issue instr 0x00A0_0177-pattern (opcode match, rd=2, rs1=5), commit in the same cycle, accelerator returns 7 after 3 cycles → one result with rd=2, id matched, data=7, at cycle 5.
- Fill to full: issue 4 matching instructions without commits → issue_ready_o=0 on cycle 4. Commit all four → 4 results in issue order.
- Kill middle entry: ids 1,2,3; kill id 2 → acc dispatches only ids 1 and 3; results for ids 1 and 3 only.
- Non-matching opcode 0x33 → accept=0 and the buffer count is unchanged.
- result_ready_i held low 10 cycles → result outputs stay stable. Further instructions stall once the buffer is full.
- Reset asserted with 3 entries in flight → all outputs at reset values next cycle; subsequent issue works from slot 0.

Source files
------------

// File: rtl/xif_coproc_tracker_pkg.sv
// Shared types for the XIF coprocessor tracker: entry lifecycle states, the
// buffered entry record and the default instruction-match constants.
package xif_coproc_tracker_pkg;

  localparam logic [6:0] DEF_OPCODE = 7'b1110111;
  localparam logic [2:0] DEF_FUNC3  = 3'b000;

  // Entry field widths; the tracker parameters must not exceed these.
  localparam int unsigned ENT_WIDTH     = 32;
  localparam int unsigned ENT_IMM_WIDTH = 12;
  localparam int unsigned ENT_ID_WIDTH  = 4;

  typedef enum logic [2:0] {
    FREE       = 3'd0,
    ISSUED     = 3'd1,
    COMMITTED  = 3'd2,
    DISPATCHED = 3'd3,
    DONE       = 3'd4,
    KILLED     = 3'd5
  } entry_state_e;

  typedef struct packed {
    entry_state_e             state;
    logic [ENT_ID_WIDTH-1:0]  id;
    logic [4:0]               rd;
    logic [ENT_WIDTH-1:0]     rs1;
    logic [ENT_IMM_WIDTH-1:0] imm;
    logic [ENT_WIDTH-1:0]     result;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    state:  FREE,
    id:     {ENT_ID_WIDTH{1'b0}},
    rd:     5'd0,
    rs1:    {ENT_WIDTH{1'b0}},
    imm:    {ENT_IMM_WIDTH{1'b0}},
    result: {ENT_WIDTH{1'b0}}
  };

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/xif_coproc_tracker_stats.sv
// Saturating event counters for issued, killed and retired instructions.
// Only instantiated when XIF_COPROC_TRACKER_STATS_EN is defined.
module xif_coproc_tracker_stats
  import xif_coproc_tracker_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issued_evt,
  input  logic        killed_evt,
  input  logic        retired_evt,
  output logic [31:0] issued_cnt,
  output logic [31:0] killed_cnt,
  output logic [31:0] retired_cnt
);

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_cnt  <= 32'd0;
      killed_cnt  <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      issued_cnt  <= issued_evt  ? sat_inc32(issued_cnt)  : issued_cnt;
      killed_cnt  <= killed_evt  ? sat_inc32(killed_cnt)  : killed_cnt;
      retired_cnt <= retired_evt ? sat_inc32(retired_cnt) : retired_cnt;
    end
  end

endmodule

// File: rtl/xif_coproc_tracker.sv
// In-order XIF front end for single-operand immediate accelerators.
// Optional statistics counters: define XIF_COPROC_TRACKER_STATS_EN.
module xif_coproc_tracker
  import xif_coproc_tracker_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 12,
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned DEPTH     = 4,
  parameter logic [6:0]  OPCODE    = DEF_OPCODE,
  parameter logic [2:0]  FUNC3     = DEF_FUNC3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [31:0]          issue_instr_i,
  input  logic [ID_WIDTH-1:0]  issue_id_i,
  input  logic [WIDTH-1:0]     issue_rs1_i,
  input  logic                 issue_rs1_valid_i,
  output logic                 issue_accept_o,
  output logic                 issue_writeback_o,
  input  logic                 commit_valid_i,
  input  logic [ID_WIDTH-1:0]  commit_id_i,
  input  logic                 commit_kill_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [WIDTH-1:0]     acc_rs1_o,
  output logic [IMM_WIDTH-1:0] acc_imm_o,
  input  logic                 acc_valid_i,
  output logic                 acc_ready_o,
  input  logic [WIDTH-1:0]     acc_result_i,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [ID_WIDTH-1:0]  result_id_o,
  output logic [4:0]           result_rd_o,
  output logic                 result_we_o,
  output logic [WIDTH-1:0]     result_data_o
`ifdef XIF_COPROC_TRACKER_STATS_EN
  ,
  output logic [31:0]          issued_cnt_o,
  output logic [31:0]          killed_cnt_o,
  output logic [31:0]          retired_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

  entry_t           ent_r [DEPTH];
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] disp_r;
  logic [CNT_W-1:0] count_r;
  // Entries between head and the dispatch pointer, so a killed head entry
  // is only freed once dispatch has walked past it.
  logic [CNT_W-1:0] passed_r;

  logic             match_s;
  logic             full_s;
  logic             issue_fire_s;
  logic             commit_byp_s;
  logic             disp_ok_s;
  logic             disp_fire_s;
  logic             disp_adv_s;
  logic             head_free_s;
  logic             res_hit_s;
  logic             res_fire_s;
  logic [PTR_W-1:0] res_idx_s;
  entry_t           disp_ent_s;
  entry_t           head_ent_s;
  logic             unused_instr_s;

  assign unused_instr_s = ^issue_instr_i[31-IMM_WIDTH:15];
  assign acc_ready_o    = 1'b1;

  // Issue decode, pointer-side status and handshake qualifiers.
  always_comb begin
    match_s           = (issue_instr_i[6:0] == OPCODE) && (issue_instr_i[14:12] == FUNC3);
    full_s            = (count_r == CNT_W'(DEPTH));
    issue_ready_o     = !full_s && (!match_s || issue_rs1_valid_i);
    issue_accept_o    = match_s;
    issue_writeback_o = match_s;
    issue_fire_s      = issue_valid_i && issue_ready_o && match_s;
    commit_byp_s      = issue_fire_s && commit_valid_i && (commit_id_i == issue_id_i);

    disp_ent_s  = ent_r[disp_r];
    head_ent_s  = ent_r[head_r];
    disp_ok_s   = (passed_r != count_r);
    acc_valid_o = disp_ok_s && (disp_ent_s.state == COMMITTED);
    disp_fire_s = acc_valid_o && acc_ready_i;
    disp_adv_s  = disp_fire_s || (disp_ok_s && (disp_ent_s.state == KILLED));

    result_valid_o = (head_ent_s.state == DONE);
    result_we_o    = result_valid_o;
    head_free_s    = (result_valid_o && result_ready_i) ||
                     ((head_ent_s.state == KILLED) && (passed_r != CNT_W'(1'b0)));

    acc_rs1_o     = acc_valid_o ? WIDTH'(disp_ent_s.rs1) : {WIDTH{1'b0}};
    acc_imm_o     = acc_valid_o ? IMM_WIDTH'(disp_ent_s.imm) : {IMM_WIDTH{1'b0}};
    result_id_o   = result_valid_o ? ID_WIDTH'(head_ent_s.id) : {ID_WIDTH{1'b0}};
    result_rd_o   = result_valid_o ? head_ent_s.rd : 5'd0;
    result_data_o = result_valid_o ? WIDTH'(head_ent_s.result) : {WIDTH{1'b0}};

    // Results come back in dispatch order, i.e. to the oldest DISPATCHED entry.
    res_hit_s = 1'b0;
    res_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (!res_hit_s && (ent_r[head_r + PTR_W'(i)].state == DISPATCHED)) begin
        res_hit_s = 1'b1;
        res_idx_s = head_r + PTR_W'(i);
      end else begin
        res_hit_s = res_hit_s;
      end
    end
    res_fire_s = acc_valid_i && res_hit_s;
  end

  // Entry lifecycle, ring pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= ENTRY_RESET;
      end
      tail_r   <= {PTR_W{1'b0}};
      head_r   <= {PTR_W{1'b0}};
      disp_r   <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      passed_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && (ent_r[i].state == ISSUED) &&
            (ent_r[i].id == ENT_ID_WIDTH'(commit_id_i))) begin
          ent_r[i].state <= commit_kill_i ? KILLED : COMMITTED;
        end
      end
      if (issue_fire_s) begin
        ent_r[tail_r].state  <= commit_byp_s ? (commit_kill_i ? KILLED : COMMITTED) : ISSUED;
        ent_r[tail_r].id     <= ENT_ID_WIDTH'(issue_id_i);
        ent_r[tail_r].rd     <= issue_instr_i[11:7];
        ent_r[tail_r].rs1    <= ENT_WIDTH'(issue_rs1_i);
        ent_r[tail_r].imm    <= ENT_IMM_WIDTH'(issue_instr_i[31 -: IMM_WIDTH]);
        ent_r[tail_r].result <= {ENT_WIDTH{1'b0}};
        tail_r               <= tail_r + PTR_ONE;
      end
      if (disp_fire_s) begin
        ent_r[disp_r].state <= DISPATCHED;
      end
      if (disp_adv_s) begin
        disp_r <= disp_r + PTR_ONE;
      end
      if (res_fire_s) begin
        ent_r[res_idx_s].state  <= DONE;
        ent_r[res_idx_s].result <= ENT_WIDTH'(acc_result_i);
      end
      if (head_free_s) begin
        ent_r[head_r].state <= FREE;
        head_r              <= head_r + PTR_ONE;
      end
      count_r  <= count_r + CNT_W'(issue_fire_s) - CNT_W'(head_free_s);
      passed_r <= passed_r + CNT_W'(disp_adv_s) - CNT_W'(head_free_s);
    end
  end

`ifdef XIF_COPROC_TRACKER_STATS_EN
  logic kill_evt_s;

  // A kill counts once, whether it hits a buffered entry or the one being issued.
  always_comb begin
    kill_evt_s = commit_byp_s && commit_kill_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && commit_kill_i && (ent_r[i].state == ISSUED) &&
          (ent_r[i].id == ENT_ID_WIDTH'(commit_id_i))) begin
        kill_evt_s = 1'b1;
      end else begin
        kill_evt_s = kill_evt_s;
      end
    end
  end

  xif_coproc_tracker_stats u_stats (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issued_evt  (issue_fire_s),
    .killed_evt  (kill_evt_s),
    .retired_evt (result_valid_o && result_ready_i),
    .issued_cnt  (issued_cnt_o),
    .killed_cnt  (killed_cnt_o),
    .retired_cnt (retired_cnt_o)
  );
`endif

endmodule

// File: tb/tb_xif_coproc_tracker.sv
// Directed bench for xif_coproc_tracker: decode table plus multi-cycle
// sequences against a small accelerator model (result = rs1 + 2).
module tb_xif_coproc_tracker;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, issue_ready_o, issue_rs1_valid_i;
  logic [31:0] issue_instr_i, issue_rs1_i;
  logic [3:0]  issue_id_i, commit_id_i, result_id_o;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i, commit_kill_i;
  logic        acc_valid_o, acc_ready_i, acc_valid_i, acc_ready_o;
  logic [31:0] acc_rs1_o, acc_result_i, result_data_o;
  logic [11:0] acc_imm_o;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [4:0]  result_rd_o;
`ifdef XIF_COPROC_TRACKER_STATS_EN
  logic [31:0] issued_cnt_o, killed_cnt_o, retired_cnt_o;
`endif

  always #5 clk = ~clk;

  xif_coproc_tracker dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs1_valid_i(issue_rs1_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .acc_rs1_o(acc_rs1_o), .acc_imm_o(acc_imm_o),
    .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_result_i(acc_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_data_o(result_data_o)
`ifdef XIF_COPROC_TRACKER_STATS_EN
    , .issued_cnt_o(issued_cnt_o), .killed_cnt_o(killed_cnt_o), .retired_cnt_o(retired_cnt_o)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_lat = 1;

  logic [31:0] acc_q_data[$];
  int          acc_q_due[$];
  logic [31:0] disp_log[$];
  logic [3:0]  res_id[$];
  logic [4:0]  res_rd[$];
  logic [31:0] res_data[$];
  logic        res_we[$];
  int          res_cyc[$];

  typedef struct {
    logic [31:0] instr;
    logic        rs1v;
    logic        exp_acc;
    logic        exp_rdy;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [11:0] imm, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  task automatic set_idle();
    issue_valid_i = 1'b0;
    issue_rs1_valid_i = 1'b0;
    issue_instr_i = 32'd0;
    issue_id_i = 4'd0;
    issue_rs1_i = 32'd0;
    commit_valid_i = 1'b0;
    commit_id_i = 4'd0;
    commit_kill_i = 1'b0;
  endtask

  task automatic clear_logs();
    disp_log.delete(); res_id.delete(); res_rd.delete();
    res_data.delete(); res_we.delete(); res_cyc.delete();
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (res_id.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("result_count", 32'(res_id.size()), 32'(n));
  endtask

  // Accelerator model: fixed latency, in-order, returns rs1 + 2.
  initial begin
    acc_valid_i = 1'b0;
    acc_result_i = 32'd0;
    forever begin
      @(negedge clk);
      if (acc_q_due.size() > 0 && acc_q_due[0] <= cyc) begin
        acc_valid_i = 1'b1;
        acc_result_i = acc_q_data[0];
      end else begin
        acc_valid_i = 1'b0;
        acc_result_i = 32'd0;
      end
      #4;
      if (rst_i) begin
        acc_q_data.delete();
        acc_q_due.delete();
      end else begin
        if (acc_valid_i && acc_ready_o) begin
          acc_q_data.delete(0);
          acc_q_due.delete(0);
        end
        if (acc_valid_o && acc_ready_i) begin
          disp_log.push_back(acc_rs1_o);
          acc_q_data.push_back(acc_rs1_o + 32'd2);
          acc_q_due.push_back(cyc + acc_lat);
        end
      end
    end
  end

  // Result collector: records every XIF result handshake just before the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_i && result_valid_o && result_ready_i) begin
        res_id.push_back(result_id_o);
        res_rd.push_back(result_rd_o);
        res_data.push_back(result_data_o);
        res_we.push_back(result_we_o);
        res_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    vecs[0] = '{mk(12'h00A, 3'b000, 5'd2, 7'h77), 1'b1, 1'b1, 1'b1};
    vecs[1] = '{mk(12'h00A, 3'b000, 5'd2, 7'h77), 1'b0, 1'b1, 1'b0};
    vecs[2] = '{mk(12'h000, 3'b000, 5'd3, 7'h33), 1'b0, 1'b0, 1'b1};
    vecs[3] = '{mk(12'h123, 3'b001, 5'd4, 7'h77), 1'b0, 1'b0, 1'b1};
    vecs[4] = '{mk(12'hFFF, 3'b000, 5'd31, 7'h77), 1'b1, 1'b1, 1'b1};
    vecs[5] = '{mk(12'h00A, 3'b000, 5'd2, 7'h76), 1'b0, 1'b0, 1'b1};

    set_idle();
    rst_i = 1'b1;
    acc_ready_i = 1'b1;
    result_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("rst_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_result_we", {31'd0, result_we_o}, 32'd0);
    chk("rst_result_data", result_data_o, 32'd0);
    chk("rst_acc_rs1", acc_rs1_o, 32'd0);
    rst_i = 1'b0;

    // Decode table at idle (no valid, so no state change).
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_idle();
      issue_instr_i = vecs[i].instr;
      issue_rs1_valid_i = vecs[i].rs1v;
      #1;
      chk("tbl_accept", {31'd0, issue_accept_o}, {31'd0, vecs[i].exp_acc});
      chk("tbl_writeback", {31'd0, issue_writeback_o}, {31'd0, vecs[i].exp_acc});
      chk("tbl_ready", {31'd0, issue_ready_o}, {31'd0, vecs[i].exp_rdy});
    end

    // Single instruction, commit in the issue cycle, 3-cycle accelerator.
    @(negedge clk);
    set_idle();
    clear_logs();
    acc_lat = 3;
    issue_valid_i = 1'b1;
    issue_instr_i = 32'h00A0_0177;
    issue_id_i = 4'd3;
    issue_rs1_i = 32'd5;
    issue_rs1_valid_i = 1'b1;
    commit_valid_i = 1'b1;
    commit_id_i = 4'd3;
    t0 = cyc;
    @(negedge clk);
    set_idle();
    #1;
    chk("single_acc_valid", {31'd0, acc_valid_o}, 32'd1);
    chk("single_acc_rs1", acc_rs1_o, 32'd5);
    chk("single_acc_imm", {20'd0, acc_imm_o}, 32'h00A);
    wait_results(1, 20);
    if (res_id.size() >= 1) begin
      chk("single_id", {28'd0, res_id[0]}, 32'd3);
      chk("single_rd", {27'd0, res_rd[0]}, 32'd2);
      chk("single_data", res_data[0], 32'd7);
      chk("single_we", {31'd0, res_we[0]}, 32'd1);
      chk("single_latency", 32'(res_cyc[0] - t0), 32'd5);
    end

    // Fill to full without commits, then commit all four.
    @(negedge clk);
    clear_logs();
    acc_lat = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      issue_valid_i = 1'b1;
      issue_instr_i = mk(12'd0, 3'b000, 5'(i + 1), 7'h77);
      issue_id_i = 4'(4 + i);
      issue_rs1_i = 32'(100 + i);
      issue_rs1_valid_i = 1'b1;
      #1;
      chk("fill_ready", {31'd0, issue_ready_o}, 32'd1);
    end
    @(negedge clk);
    issue_id_i = 4'd9;
    #1;
    chk("full_ready", {31'd0, issue_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      commit_valid_i = 1'b1;
      commit_id_i = 4'(4 + i);
    end
    @(negedge clk);
    set_idle();
    wait_results(4, 40);
    for (int i = 0; i < 4 && i < res_id.size(); i++) begin
      chk("fill_order_id", {28'd0, res_id[i]}, 32'(4 + i));
      chk("fill_data", res_data[i], 32'(102 + i));
      chk("fill_rd", {27'd0, res_rd[i]}, 32'(i + 1));
    end

    // Kill the middle of three instructions.
    @(negedge clk);
    clear_logs();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_idle();
      issue_valid_i = 1'b1;
      issue_instr_i = mk(12'd0, 3'b000, 5'(10 + i), 7'h77);
      issue_id_i = 4'(i);
      issue_rs1_i = 32'(10 * i);
      issue_rs1_valid_i = 1'b1;
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_idle();
      commit_valid_i = 1'b1;
      commit_id_i = 4'(i);
      commit_kill_i = (i == 2);
    end
    @(negedge clk);
    set_idle();
    wait_results(2, 40);
    repeat (10) @(negedge clk);
    chk("kill_result_total", 32'(res_id.size()), 32'd2);
    chk("kill_disp_total", 32'(disp_log.size()), 32'd2);
    if (res_id.size() >= 2 && disp_log.size() >= 2) begin
      chk("kill_res0_id", {28'd0, res_id[0]}, 32'd1);
      chk("kill_res1_id", {28'd0, res_id[1]}, 32'd3);
      chk("kill_res1_data", res_data[1], 32'd32);
      chk("kill_disp0", disp_log[0], 32'd10);
      chk("kill_disp1", disp_log[1], 32'd30);
    end

    // Non-matching issue consumes no slot; then stall on result_ready low.
    @(negedge clk);
    clear_logs();
    result_ready_i = 1'b0;
    set_idle();
    issue_valid_i = 1'b1;
    issue_instr_i = mk(12'd0, 3'b000, 5'd3, 7'h33);
    #1;
    chk("nomatch_accept", {31'd0, issue_accept_o}, 32'd0);
    chk("nomatch_ready", {31'd0, issue_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      issue_valid_i = 1'b1;
      issue_instr_i = mk(12'd0, 3'b000, 5'(i + 1), 7'h77);
      issue_id_i = 4'(8 + i);
      issue_rs1_i = 32'(200 + i);
      issue_rs1_valid_i = 1'b1;
      commit_valid_i = 1'b1;
      commit_id_i = 4'(8 + i);
      #1;
      chk("stall_fill_ready", {31'd0, issue_ready_o}, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_idle();
      issue_valid_i = 1'b1;
      issue_instr_i = mk(12'd0, 3'b000, 5'd9, 7'h77);
      issue_id_i = 4'd12;
      issue_rs1_i = 32'd999;
      issue_rs1_valid_i = 1'b1;
      #1;
      chk("stall_valid", {31'd0, result_valid_o}, 32'd1);
      chk("stall_id", {28'd0, result_id_o}, 32'd8);
      chk("stall_data", result_data_o, 32'd202);
      chk("stall_issue_ready", {31'd0, issue_ready_o}, 32'd0);
    end
    @(negedge clk);
    set_idle();
    result_ready_i = 1'b1;
    wait_results(4, 40);
    repeat (6) @(negedge clk);
    chk("stall_result_total", 32'(res_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < res_id.size(); i++) begin
      chk("stall_order_id", {28'd0, res_id[i]}, 32'(8 + i));
      chk("stall_order_data", res_data[i], 32'(202 + i));
    end

    // Reset with three entries in flight.
    @(negedge clk);
    clear_logs();
    acc_lat = 6;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_idle();
      issue_valid_i = 1'b1;
      issue_instr_i = mk(12'd0, 3'b000, 5'(i), 7'h77);
      issue_id_i = 4'(i);
      issue_rs1_i = 32'(50 + i);
      issue_rs1_valid_i = 1'b1;
      commit_valid_i = 1'b1;
      commit_id_i = 4'(i);
    end
    @(negedge clk);
    set_idle();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_issue_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("mid_rst_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    chk("mid_rst_result_valid", {31'd0, result_valid_o}, 32'd0);
    chk("mid_rst_we", {31'd0, result_we_o}, 32'd0);
    chk("mid_rst_acc_rs1", acc_rs1_o, 32'd0);
    chk("mid_rst_result_id", {28'd0, result_id_o}, 32'd0);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_results", 32'(res_id.size()), 32'd0);
    acc_lat = 1;
    @(negedge clk);
    set_idle();
    issue_valid_i = 1'b1;
    issue_instr_i = mk(12'd0, 3'b000, 5'd7, 7'h77);
    issue_id_i = 4'd5;
    issue_rs1_i = 32'd40;
    issue_rs1_valid_i = 1'b1;
    commit_valid_i = 1'b1;
    commit_id_i = 4'd5;
    @(negedge clk);
    set_idle();
    wait_results(1, 20);
    if (res_id.size() >= 1) begin
      chk("post_rst_id", {28'd0, res_id[0]}, 32'd5);
      chk("post_rst_rd", {27'd0, res_rd[0]}, 32'd7);
      chk("post_rst_data", res_data[0], 32'd42);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
